// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Target end of the CPU load/store port; one request at a time,
//            fixed wait states, right-aligned raw read data.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 512,
   parameter int unsigned LATENCY     = 2,
   parameter logic [63:0] BASE_ADDR   = 64'h0
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [63:0] req_addr_i,
   input  logic [1:0]  req_size_i,
   input  logic [63:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [63:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int unsigned c_idx_w = $clog2(DEPTH_WORDS);
   localparam logic [63:0] c_span  = 64'(DEPTH_WORDS) * 64'd8;
   localparam logic [3:0]  c_lat   = 4'(LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         we_q;
   logic [63:0]  addr_q;
   logic [1:0]   size_q;
   logic [63:0]  wdata_q;
   logic [63:0]  rdata_q, rdata_d;
   logic         err_q, err_d;

   logic         w_accept;
   logic         w_commit;
   logic [63:0]  w_offset;
   logic [2:0]   w_lane;
   logic [2:0]   w_align_mask;
   logic [7:0]   w_size_be;
   logic [63:0]  w_size_mask;
   logic         w_misalign;
   logic         w_oor;
   logic         w_err;
   logic [c_idx_w-1:0] w_idx;
   logic [7:0]   w_be;
   logic [63:0]  w_wdata_sh;
   logic [63:0]  w_word;
   logic [63:0]  w_merged;
   logic [63:0]  w_load;
   logic         w_mem_we;

   logic [63:0]  mem_q [DEPTH_WORDS];

   // Access decode works on the latched request, so it is stable through BUSY.
   assign w_offset = addr_q - BASE_ADDR;
   assign w_lane   = addr_q[2:0];

   always_comb begin
      w_align_mask = 3'b000;
      w_size_be    = 8'h01;
      w_size_mask  = 64'h0000_0000_0000_00FF;
      case (size_q)
         2'd0: begin
            w_align_mask = 3'b000;
            w_size_be    = 8'h01;
            w_size_mask  = 64'h0000_0000_0000_00FF;
         end
         2'd1: begin
            w_align_mask = 3'b001;
            w_size_be    = 8'h03;
            w_size_mask  = 64'h0000_0000_0000_FFFF;
         end
         2'd2: begin
            w_align_mask = 3'b011;
            w_size_be    = 8'h0F;
            w_size_mask  = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            w_align_mask = 3'b111;
            w_size_be    = 8'hFF;
            w_size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
         end
      endcase
   end

   assign w_misalign = |(w_lane & w_align_mask);
   assign w_oor      = (w_offset >= c_span);
   assign w_err      = w_misalign | w_oor;
   assign w_idx      = w_offset[3 +: c_idx_w];
   assign w_be       = w_size_be << w_lane;
   assign w_wdata_sh = wdata_q << {w_lane, 3'b000};
   assign w_word     = mem_q[w_idx];
   assign w_load     = (w_word >> {w_lane, 3'b000}) & w_size_mask;
   assign w_mem_we   = w_commit & we_q & ~w_err;

   for (genvar b = 0; b < 8; b++) begin : g_lane
      assign w_merged[8*b +: 8] = w_be[b] ? w_wdata_sh[8*b +: 8] : w_word[8*b +: 8];
   end

   // Counter runs down to zero and the commit happens on the edge that sees
   // zero, so a response is visible LATENCY+1 cycles after the accept edge.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      w_accept = 1'b0;
      w_commit = 1'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               w_accept = 1'b1;
               cnt_d    = c_lat;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == 4'd0) begin
               w_commit = 1'b1;
               rdata_d  = (we_q | w_err) ? 64'h0 : w_load;
               err_d    = w_err;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 64'h0;
         size_q  <= 2'd0;
         wdata_q <= 64'h0;
         rdata_q <= 64'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (w_accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            size_q  <= req_size_i;
            wdata_q <= req_wdata_i;
         end
      end
   end

   // Array has no reset; an aborted request never reaches BUSY-commit.
   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         mem_q[w_idx] <= w_merged;
      end
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign resp_valid_o = (state_q == S_RESP);
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Bench for dmem_responder over four parameter sets, byte-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

   localparam int NI = 4;

   function automatic int unsigned lat_of(input int g);
      case (g)
         0:       return 2;
         1:       return 0;
         2:       return 4;
         default: return 3;
      endcase
   endfunction

   function automatic int unsigned depth_of(input int g);
      return (g == 3) ? 64 : 512;
   endfunction

   function automatic logic [63:0] base_of(input int g);
      return (g == 3) ? 64'h1000 : 64'h0;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n      [NI];
   logic        req_valid  [NI];
   logic        req_ready  [NI];
   logic        req_we     [NI];
   logic [63:0] req_addr   [NI];
   logic [1:0]  req_size   [NI];
   logic [63:0] req_wdata  [NI];
   logic        resp_valid [NI];
   logic        resp_ready [NI];
   logic [63:0] resp_rdata [NI];
   logic        resp_err   [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(
         .DEPTH_WORDS (depth_of(g)),
         .LATENCY     (lat_of(g)),
         .BASE_ADDR   (base_of(g))
      ) u_dut (
         .clk_i        (clk),
         .rst_n_i      (rst_n[g]),
         .req_valid_i  (req_valid[g]),
         .req_ready_o  (req_ready[g]),
         .req_we_i     (req_we[g]),
         .req_addr_i   (req_addr[g]),
         .req_size_i   (req_size[g]),
         .req_wdata_i  (req_wdata[g]),
         .resp_valid_o (resp_valid[g]),
         .resp_ready_i (resp_ready[g]),
         .resp_rdata_o (resp_rdata[g]),
         .resp_err_o   (resp_err[g])
      );
   end

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
      end
   endtask

   // Byte-addressed shadow of each array, indexed by offset from BASE_ADDR.
   logic [7:0] mref [NI][4096];

   task automatic model(input int k, input bit we, input logic [63:0] addr,
                        input logic [1:0] size, input logic [63:0] wd,
                        output logic [63:0] exp_rd, output logic exp_err);
      int unsigned n;
      logic [63:0] off;
      int          idx;
      n       = 1 << size;
      off     = addr - base_of(k);
      exp_rd  = 64'h0;
      exp_err = ((addr % n) != 0) || (off >= 64'(depth_of(k)) * 64'd8);
      if (!exp_err) begin
         for (int i = 0; i < int'(n); i++) begin
            idx = int'(off[11:0]) + i;
            if (we) mref[k][idx] = wd[8*i +: 8];
            else    exp_rd = exp_rd | (64'(mref[k][idx]) << (8*i));
         end
      end
   endtask

   // Starts just after a clock edge; returns just after the response handshake.
   task automatic txn(input int k, input bit we, input logic [63:0] addr,
                      input logic [1:0] size, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output int lat);
      int w;
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = addr;
      req_size[k]  = size;
      req_wdata[k] = wd;
      w = 0;
      while (!req_ready[k] && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!req_ready[k]) check("accept_timeout", {63'h0, req_ready[k]}, 64'h1);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      lat = 0;
      while (!resp_valid[k] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = resp_rdata[k];
      er = resp_err[k];
      if (resp_valid[k] && resp_ready[k]) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic run(input int k, input bit we, input logic [63:0] addr,
                      input logic [1:0] size, input logic [63:0] wd, input bit chk_data);
      logic [63:0] exp_rd, rd;
      logic        exp_err, er;
      int          lat;
      model(k, we, addr, size, wd, exp_rd, exp_err);
      txn(k, we, addr, size, wd, rd, er, lat);
      check($sformatf("u%0d err @%h", k, addr), {63'h0, er}, {63'h0, exp_err});
      if (chk_data) check($sformatf("u%0d rdata @%h", k, addr), rd, exp_rd);
      check($sformatf("u%0d latency", k), 64'(lat), 64'(lat_of(k) + 1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] rd, addr, wd;
      logic        er;
      int          lat, w, r;
      logic [1:0]  sz;
      bit          we;

      for (int k = 0; k < NI; k++) begin
         rst_n[k]      = 1'b0;
         req_valid[k]  = 1'b0;
         req_we[k]     = 1'b0;
         req_addr[k]   = 64'h0;
         req_size[k]   = 2'd0;
         req_wdata[k]  = 64'h0;
         resp_ready[k] = 1'b1;
      end
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("u%0d rst ready", k), {63'h0, req_ready[k]}, 64'h1);
         check($sformatf("u%0d rst valid", k), {63'h0, resp_valid[k]}, 64'h0);
         check($sformatf("u%0d rst rdata", k), resp_rdata[k], 64'h0);
         check($sformatf("u%0d rst err", k), {63'h0, resp_err[k]}, 64'h0);
      end
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

      // Give the words used by random traffic defined contents.
      for (int i = 0; i < 32; i++) begin
         run(0, 1'b1, 64'(i * 8), 2'd3, {$urandom, $urandom}, 1'b1);
         run(3, 1'b1, 64'h1000 + 64'(i * 8), 2'd3, {$urandom, $urandom}, 1'b1);
      end

      // Byte/half store and load on LATENCY=2.
      run(0, 1'b1, 64'h10, 2'd3, 64'h1122334455667788, 1'b1);
      run(0, 1'b1, 64'h13, 2'd0, 64'h00000000000000AB, 1'b1);
      txn(0, 1'b0, 64'h10, 2'd3, 64'h0, rd, er, lat);
      check("ld 0x10", rd, 64'h11223344AB667788);
      check("ld 0x10 latency", 64'(lat), 64'd3);
      txn(0, 1'b0, 64'h16, 2'd1, 64'h0, rd, er, lat);
      check("lh 0x16", rd, 64'h0000000000001122);
      txn(0, 1'b0, 64'h12, 2'd2, 64'h0, rd, er, lat);
      check("lw 0x12 err", {63'h0, er}, 64'h1);
      check("lw 0x12 rdata", rd, 64'h0);
      run(0, 1'b1, 64'h21, 2'd3, 64'hCAFEF00DCAFEF00D, 1'b1);
      run(0, 1'b0, 64'h20, 2'd3, 64'h0, 1'b1);
      txn(0, 1'b0, 64'd4096, 2'd3, 64'h0, rd, er, lat);
      check("ld top+0 err", {63'h0, er}, 64'h1);
      txn(0, 1'b0, 64'd4088, 2'd3, 64'h0, rd, er, lat);
      check("ld top-8 err", {63'h0, er}, 64'h0);
      txn(3, 1'b0, 64'h0FF8, 2'd3, 64'h0, rd, er, lat);
      check("ld below base err", {63'h0, er}, 64'h1);
      run(3, 1'b0, 64'h1000, 2'd3, 64'h0, 1'b1);
      run(3, 1'b0, 64'h1000 + 64'd512, 2'd3, 64'h0, 1'b1);

      // Backpressure with a second request offered during RESP.
      resp_ready[0] = 1'b0;
      req_valid[0]  = 1'b1;
      req_we[0]     = 1'b0;
      req_addr[0]   = 64'h10;
      req_size[0]   = 2'd3;
      @(posedge clk); #1;
      check("bp accepted", {63'h0, req_ready[0]}, 64'h0);
      req_addr[0] = 64'h16;
      req_size[0] = 2'd1;
      w = 0;
      while (!resp_valid[0] && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      check("bp latency", 64'(w), 64'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp valid", {63'h0, resp_valid[0]}, 64'h1);
         check("bp rdata", resp_rdata[0], 64'h11223344AB667788);
         check("bp err", {63'h0, resp_err[0]}, 64'h0);
         check("bp ready", {63'h0, req_ready[0]}, 64'h0);
      end
      resp_ready[0] = 1'b1;
      @(posedge clk); #1;
      check("bp released valid", {63'h0, resp_valid[0]}, 64'h0);
      check("bp released ready", {63'h0, req_ready[0]}, 64'h1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      check("bp second accepted", {63'h0, req_ready[0]}, 64'h0);
      lat = 0;
      while (!resp_valid[0] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("bp second latency", 64'(lat), 64'd3);
      check("bp second rdata", resp_rdata[0], 64'h0000000000001122);
      @(posedge clk); #1;

      // LATENCY=0, back-to-back.
      run(1, 1'b1, 64'h8, 2'd2, 64'h00000000DEADBEEF, 1'b1);
      txn(1, 1'b0, 64'h8, 2'd2, 64'h0, rd, er, lat);
      check("lat0 lw", rd, 64'h00000000DEADBEEF);
      check("lat0 latency", 64'(lat), 64'd1);

      // Reset mid-operation on LATENCY=4.
      run(2, 1'b1, 64'h0, 2'd3, 64'h0123456789ABCDEF, 1'b1);
      run(2, 1'b0, 64'h0, 2'd3, 64'h0, 1'b1);
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b1;
      req_addr[2]  = 64'h0;
      req_size[2]  = 2'd3;
      req_wdata[2] = 64'hFF;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      check("rst accepted", {63'h0, req_ready[2]}, 64'h0);
      @(posedge clk); #1;
      rst_n[2] = 1'b0;
      #1;
      check("midrst ready", {63'h0, req_ready[2]}, 64'h1);
      check("midrst valid", {63'h0, resp_valid[2]}, 64'h0);
      check("midrst rdata", resp_rdata[2], 64'h0);
      check("midrst err", {63'h0, resp_err[2]}, 64'h0);
      repeat (6) @(posedge clk);
      #1;
      rst_n[2] = 1'b1;
      txn(2, 1'b0, 64'h0, 2'd3, 64'h0, rd, er, lat);
      check("midrst store dropped", rd, 64'h0123456789ABCDEF);

      // A store that already committed survives reset during RESP.
      resp_ready[2] = 1'b0;
      txn(2, 1'b1, 64'h8, 2'd3, 64'h55, rd, er, lat);
      check("committed store latency", 64'(lat), 64'd5);
      model(2, 1'b1, 64'h8, 2'd3, 64'h55, rd, er);
      rst_n[2] = 1'b0;
      #1;
      check("resp rst valid", {63'h0, resp_valid[2]}, 64'h0);
      @(posedge clk); #1;
      rst_n[2] = 1'b1;
      resp_ready[2] = 1'b1;
      run(2, 1'b0, 64'h8, 2'd3, 64'h0, 1'b1);

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         int k;
         k  = (i % 2 == 0) ? 0 : 3;
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         wd = {$urandom, $urandom};
         r  = int'($urandom_range(0, 99));
         if (r < 6)
            addr = base_of(k) + 64'(depth_of(k)) * 64'd8 + 64'($urandom_range(0, 63));
         else if (r < 12)
            addr = base_of(k) - 64'd8 - 64'($urandom_range(0, 63));
         else
            addr = base_of(k) + 64'($urandom_range(0, 31) * 8) + 64'($urandom_range(0, 7));
         run(k, we, addr, sz, wd, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
